// File: rtl/redun_carry_prop.sv
// Resolves a redundant-form operand (WRD_BITS+1 bits per word) into a fully carried value,
// WRDS_PER_CYC words per clock, flagging any carry out of the top word.
module redun_carry_prop #(
    parameter int unsigned WRD_BITS     = 16,
    parameter int unsigned NUM_WRDS     = 65,
    parameter int unsigned WRDS_PER_CYC = 5
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]   i_dat,
    input  logic                               i_val,
    output logic                               o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]       o_dat,
    output logic                               o_ovf,
    output logic                               o_val,
    input  logic                               i_rdy
);

    localparam int unsigned RedW     = WRD_BITS + 1;
    localparam int unsigned NumCyc   = NUM_WRDS / WRDS_PER_CYC;
    localparam int unsigned CntW     = (NumCyc > 1) ? $clog2(NumCyc) : 1;
    localparam int unsigned OpW      = NUM_WRDS * RedW;
    localparam int unsigned DatW     = NUM_WRDS * WRD_BITS;
    localparam int unsigned SliceW   = WRDS_PER_CYC * WRD_BITS;
    localparam int unsigned SliceOpW = WRDS_PER_CYC * RedW;

    if (NUM_WRDS % WRDS_PER_CYC != 0) begin : g_bad_cfg
        $error("NUM_WRDS must be a multiple of WRDS_PER_CYC");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [1:0]        carry_q;
    logic [OpW-1:0]    op_q;
    logic [DatW-1:0]   dat_q;
    logic              ovf_q;

    logic [SliceW-1:0]        res;
    logic [1:0]               carry_d;
    logic [WRD_BITS+1:0]      sum;
    logic [DatW+SliceW-1:0]   dat_cat;
    logic [DatW-1:0]          dat_nxt;

    // The operand is consumed from its low end; resolved words enter dat_q from the top
    // so that after NumCyc shifts every word sits at its final position.
    always_comb begin
        res     = '0;
        sum     = '0;
        carry_d = carry_q;
        for (int k = 0; k < int'(WRDS_PER_CYC); k++) begin
            sum     = {1'b0, op_q[k*RedW +: RedW]} + {WRD_BITS'(0), carry_d};
            res[k*WRD_BITS +: WRD_BITS] = sum[WRD_BITS-1:0];
            carry_d = sum[WRD_BITS+1:WRD_BITS];
        end
    end

    assign dat_cat = {res, dat_q};
    assign dat_nxt = dat_cat[DatW+SliceW-1 -: DatW];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= '0;
            op_q    <= '0;
            dat_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_val) begin
                        op_q    <= i_dat;
                        carry_q <= '0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    op_q    <= op_q >> SliceOpW;
                    dat_q   <= dat_nxt;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(NumCyc - 1)) begin
                        ovf_q   <= (carry_d != 2'd0);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (i_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_rdy = (state_q == StIdle);
    assign o_val = (state_q == StDone);
    assign o_dat = dat_q;
    assign o_ovf = ovf_q;

endmodule

// File: tb/tb_redun_carry_prop.sv
// Scoreboard bench for redun_carry_prop: directed corner cases plus randomized operands
// checked against a weighted-sum arithmetic model.
module tb_redun_carry_prop;

    localparam int W   = 16;
    localparam int NW  = 65;
    localparam int OPW = NW * (W + 1);
    localparam int DW  = NW * W;
    localparam int LAT = 13;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          ovf;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [OPW-1:0] i_dat;
    logic           i_val;
    logic           o_rdy;
    logic [DW-1:0]  o_dat;
    logic           o_ovf;
    logic           o_val;
    logic           i_rdy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rdy_mode = 0;
    int   t_acc   = 0;
    exp_t exp_q[$];

    redun_carry_prop #(
        .WRD_BITS    (16),
        .NUM_WRDS    (65),
        .WRDS_PER_CYC(5)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_dat  (i_dat),
        .i_val  (i_val),
        .o_rdy  (o_rdy),
        .o_dat  (o_dat),
        .o_ovf  (o_ovf),
        .o_val  (o_val),
        .i_rdy  (i_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        int j;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            j = 0;
            while (j < NW - 1 && act[j*W +: W] === exp[j*W +: W]) j++;
            $display("FAIL %s: word %0d got %h expected %h", name, j, act[j*W +: W],
                     exp[j*W +: W]);
        end
    endtask

    // Reference: value = sum of word[j] * 2^(16j); low 1040 bits and any higher bit.
    task automatic model(input logic [OPW-1:0] d, output logic [DW-1:0] ed, output logic eo);
        logic [DW+7:0] acc;
        logic [DW+7:0] w;
        acc = '0;
        for (int j = 0; j < NW; j++) begin
            w   = (DW + 8)'(d[j*(W+1) +: W+1]);
            acc = acc + (w << (W * j));
        end
        ed = acc[DW-1:0];
        eo = |acc[DW+7:DW];
    endtask

    task automatic send(input logic [OPW-1:0] d, input bit push, input logic [DW-1:0] ed,
                        input logic eo);
        int w;
        exp_t e;
        w     = 0;
        i_dat = d;
        i_val = 1'b1;
        while (!o_rdy && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!o_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: o_rdy got 0 expected 1");
            i_val = 1'b0;
            return;
        end
        if (push) begin
            e.dat = ed;
            e.ovf = eo;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        i_val = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_val) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic rand_op(output logic [OPW-1:0] d);
        for (int j = 0; j < NW; j++) d[j*(W+1) +: W+1] = 17'($urandom_range(0, 17'h1FFFF));
    endtask

    // Downstream ready driver
    initial begin
        i_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: i_rdy = 1'b1;
                1: i_rdy = ($urandom_range(0, 3) != 0);
                default: i_rdy = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_val && i_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(o_val), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk_dat("o_dat", o_dat, e.dat);
                    chk("o_ovf", 32'(o_ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        logic [OPW-1:0] d;
        logic [OPW-1:0] d2;
        logic [DW-1:0]  ed;
        logic [DW-1:0]  snap_dat;
        logic           snap_ovf;
        logic           eo;
        int             w;
        int             t_u;
        bit             seen;

        rst_n = 1'b0;
        i_val = 1'b0;
        i_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_o_rdy", 32'(o_rdy), 32'd1);
        chk("reset_o_val", 32'(o_val), 32'd0);
        chk("reset_o_ovf", 32'(o_ovf), 32'd0);
        chk_dat("reset_o_dat", o_dat, '0);

        // Ripple to top, with latency measurement
        d = '0;
        d[16:0] = 17'h10000;
        for (int j = 1; j < NW; j++) d[j*(W+1) +: W+1] = 17'h0FFFF;
        send(d, 1'b1, '0, 1'b1);
        w = 0;
        @(negedge clk);
        while (!o_val && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ripple_latency", 32'(cyc - t_acc), 32'(LAT));
        drain("ripple_drain");

        // Pass-through
        for (int j = 0; j < NW; j++) begin
            d[j*(W+1) +: W+1] = {1'b0, 16'($urandom)};
            ed[j*W +: W]      = d[j*(W+1) +: W];
        end
        send(d, 1'b1, ed, 1'b0);
        drain("pass_drain");

        // Max redundancy
        for (int j = 0; j < NW; j++) d[j*(W+1) +: W+1] = 17'h1FFFF;
        ed = '0;
        ed[15:0] = 16'hFFFF;
        for (int j = 2; j < NW; j++) ed[j*W +: W] = 16'h0001;
        send(d, 1'b1, ed, 1'b1);
        drain("maxred_drain");

        // Backpressure in DONE while new data is offered
        rand_op(d);
        model(d, ed, eo);
        rdy_mode = 2;
        send(d, 1'b1, ed, eo);
        w = 0;
        @(negedge clk);
        while (!o_val && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_o_val_rise", 32'(o_val), 32'd1);
        snap_dat = o_dat;
        snap_ovf = o_ovf;
        rand_op(d2);
        i_dat = d2;
        i_val = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_o_val", 32'(o_val), 32'd1);
            chk("bp_o_rdy", 32'(o_rdy), 32'd0);
            chk("bp_o_ovf", 32'(o_ovf), 32'(snap_ovf));
            chk_dat("bp_o_dat", o_dat, snap_dat);
        end
        i_val = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        t_u = cyc;
        chk("bp_after_rdy", 32'(o_rdy), 32'd1);
        chk("bp_after_val", 32'(o_val), 32'd0);
        model(d2, ed, eo);
        send(d2, 1'b1, ed, eo);
        chk("bp_next_accept", 32'(t_acc - t_u), 32'd1);
        drain("bp_drain");

        // Reset at the 6th RUN edge
        rand_op(d);
        send(d, 1'b0, '0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_run_o_rdy", 32'(o_rdy), 32'd1);
        chk("rst_run_o_ovf", 32'(o_ovf), 32'd0);
        chk_dat("rst_run_o_dat", o_dat, '0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_val) seen = 1'b1;
        end
        chk("rst_run_no_output", 32'(seen), 32'd0);
        rand_op(d);
        model(d, ed, eo);
        send(d, 1'b1, ed, eo);
        drain("rst_run_next_drain");

        // Random back-to-back with stalls
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            rand_op(d);
            model(d, ed, eo);
            send(d, 1'b1, ed, eo);
        end
        rdy_mode = 0;
        drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/redun_carry_prop.md
# redun_carry_prop

Sequential carry-resolution unit that converts a redundant-form operand (NUM_WRDS words of WRD_BITS+1 bits each) back to a normal fully-carried field element. It propagates carries over WRDS_PER_CYC words per clock to keep the adder chain short at the Montgomery core's clock rate. It sits on the output side of the redundant Montgomery squaring datapath, feeding the result to the host and checker logic. It also produces the flag that is set when the value exceeds NUM_WRDS*WRD_BITS bits.

## Interface
- WRD_BITS, 16, normal word width; each redundant word is WRD_BITS+1 bits
- NUM_WRDS, 65, words per operand (1040-bit value)
- WRDS_PER_CYC, 5, words resolved per RUN cycle; NUM_WRDS % WRDS_PER_CYC must be 0 (elaboration error otherwise)
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_dat  in  NUM_WRDS*(WRD_BITS+1)  redundant operand; word j at [j*(WRD_BITS+1) +: WRD_BITS+1], word 0 least significant
- i_val  in  1  input valid
- o_rdy  out  1  input ready
- o_dat  out  NUM_WRDS*WRD_BITS  resolved value; word j at [j*WRD_BITS +: WRD_BITS]
- o_ovf  out  1  nonzero carry out of word NUM_WRDS-1
- o_val  out  1  output valid
- i_rdy  in  1  downstream ready

## Operation
- N = NUM_WRDS/WRDS_PER_CYC RUN cycles per operand (13 at default).
- States:
  - IDLE: o_rdy=1, o_val=0. On i_val&&o_rdy, capture i_dat into the operand register, clear carry (2 bits) and word counter cnt, then go to RUN.
  - RUN: o_rdy=0. Each cycle, for j = cnt*WRDS_PER_CYC .. +WRDS_PER_CYC-1 in order: s = word[j] + c (WRD_BITS+2 bits), o_dat word j = s[WRD_BITS-1:0], c = s >> WRD_BITS.
    - c is in 0..2, because word ≤ 2^17-1 and c ≤ 2 gives s ≤ 2^17+1.
    - The carry chains combinationally within the cycle and registers between cycles.
    - cnt increments. When cnt==N-1, register o_ovf = (c_final != 0) and go to DONE.
  - DONE: o_val=1. On i_rdy, go to IDLE. o_dat and o_ovf hold stable while o_val&&!i_rdy.
- i_val during RUN/DONE is ignored; upstream must hold data until o_rdy.
- Arithmetic equivalence: o_dat = (Σ word[j]·2^(16j)) mod 2^1040; o_ovf=1 iff the sum ≥ 2^1040.
- Reset (i_rst_n=0 at an edge), in any state including mid-RUN:
  - state=IDLE, cnt=0, carry=0, o_dat=0, o_ovf=0, o_val=0.
  - The in-flight operand is discarded; no output is produced for it.

## Timing
- Reset values: o_val=0, o_rdy=1 (first cycle after reset release), o_dat=0, o_ovf=0.
- Accept at edge T. RUN edges are T+1..T+N. o_val is high starting after edge T+N. Latency is N edges (13 default).
- Output handshake at edge U (o_val&&i_rdy). o_val=0 and o_rdy=1 after U. Next accept is possible at edge U+1.
- Minimum issue interval: N+2 cycles.
- o_rdy and o_val decode directly from the state register; no combinational path exists from i_val/i_rdy to any output.
- Critical path: WRDS_PER_CYC chained (WRD_BITS+2)-bit adds.

## Test plan
- Ripple to top: word0=0x1_0000, words1..64=0x0_FFFF -> o_dat=0, o_ovf=1, o_val exactly 13 edges after accept.
- Pass-through: i_dat = P split into 16-bit words with bit16=0 -> o_dat=P, o_ovf=0.
- Max redundancy: all words 0x1_FFFF -> word0=0xFFFF, word1=0x0000, words2..64=0x0001, o_ovf=1 (final carry 2).
- Backpressure: hold i_rdy=0 for 5 cycles in DONE while driving i_val with new data -> o_val stays 1, o_dat/o_ovf unchanged, o_rdy=0, new data not captured. After i_rdy=1, the next operand is accepted one cycle later.
- Reset mid-RUN: assert i_rst_n=0 at the 6th RUN edge -> o_val never rises for that operand; o_rdy=1, o_dat=0 after reset; the following operand resolves correctly.
- Random: 1000 back-to-back operands with words uniform in 0..0x1FFFF and random i_rdy stalls -> o_dat/o_ovf match the behavioral model (weighted word sum, low 1040 bits, bit 1040 or higher set).
